// File: rtl/host_bootdata_tx.sv
// rtl/host_bootdata_tx.sv - byte-to-word packer and four-phase boot-data transmitter (optional checksum: BOOTDATA_CHECKSUM_EN)
module host_bootdata_tx #(
    parameter int WORDS = 12288,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      host_bootdata,
    output logic             host_bootdata_req,
    input  logic             host_bootdata_ack,
    input  logic             host_rom_initialised,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count
`ifdef BOOTDATA_CHECKSUM_EN
    ,
    input  logic [31:0]      expected_sum,
    output logic [31:0]      sum,
    output logic             sum_ok
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] idx;

    logic start_upload;
    logic byte_take;
    logic word_acked;

    // start is honoured only when no upload is in flight
    assign start_upload = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign byte_take    = (state == S_COLLECT) && byte_valid;
    assign word_acked   = (state == S_REQ) && host_bootdata_ack;

    assign byte_ready = (state == S_COLLECT);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);

    // Next-state decode of the upload sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_valid && (idx == 2'd3)) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (host_bootdata_ack) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // ack must return low before the next word is offered
                if (!host_bootdata_ack) begin
                    state_nxt = (word_count == LAST_COUNT) ? S_FINISH : S_COLLECT;
                end
            end
            S_FINISH: begin
                if (host_rom_initialised) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte lane index; wraps to 0 after the fourth byte so the next word starts at lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
        end else if (start_upload) begin
            idx <= 2'd0;
        end else if (byte_take) begin
            idx <= idx + 2'd1;
        end
    end

    // Word register, packed little-endian; it only changes in COLLECT so it is stable through REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_bootdata <= 32'h0000_0000;
        end else if (start_upload) begin
            host_bootdata <= 32'h0000_0000;
        end else if (byte_take) begin
            host_bootdata[{idx, 3'b000} +: 8] <= byte_data;
        end
    end

    // Request is high exactly while the sequencer sits in REQ, registered on the transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_bootdata_req <= 1'b0;
        end else begin
            host_bootdata_req <= (state_nxt == S_REQ);
        end
    end

    // Count of acknowledged words, updated on the same edge that drops req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (start_upload) begin
            word_count <= '0;
        end else if (word_acked) begin
            word_count <= word_count + CNT_ONE;
        end
    end

`ifdef BOOTDATA_CHECKSUM_EN
    // Running modulo-2^32 sum of acknowledged words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 32'h0000_0000;
        end else if (start_upload) begin
            sum <= 32'h0000_0000;
        end else if (word_acked) begin
            sum <= sum + host_bootdata;
        end
    end

    assign sum_ok = (state == S_DONE) && (sum == expected_sum);
`endif

endmodule

// File: tb/tb_host_bootdata_tx.sv
// tb/tb_host_bootdata_tx.sv - scoreboard testbench for host_bootdata_tx
module tb_host_bootdata_tx;

    localparam int WORDS = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic [31:0]      host_bootdata;
    logic             host_bootdata_req;
    logic             host_bootdata_ack;
    logic             host_rom_initialised;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_count;
`ifdef BOOTDATA_CHECKSUM_EN
    logic [31:0]      expected_sum;
    logic [31:0]      sum;
    logic             sum_ok;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic        mon_req_q;
    logic [31:0] mon_held;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    host_bootdata_tx #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .byte_data           (byte_data),
        .byte_valid          (byte_valid),
        .byte_ready          (byte_ready),
        .host_bootdata       (host_bootdata),
        .host_bootdata_req   (host_bootdata_req),
        .host_bootdata_ack   (host_bootdata_ack),
        .host_rom_initialised(host_rom_initialised),
        .busy                (busy),
        .done                (done),
        .word_count          (word_count)
`ifdef BOOTDATA_CHECKSUM_EN
        ,
        .expected_sum        (expected_sum),
        .sum                 (sum),
        .sum_ok              (sum_ok)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expected word on every rising req and checks stability while req holds
    initial begin
        mon_req_q = 1'b0;
        mon_held  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mon_req_q = 1'b0;
            end else begin
                if (host_bootdata_req && !mon_req_q) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", host_bootdata_req, 1'b0);
                    end else begin
                        chk("word_data", host_bootdata, exp_q.pop_front());
                    end
                    mon_held = host_bootdata;
                end else if (host_bootdata_req && mon_req_q) begin
                    chk("word_stable", host_bootdata, mon_held);
                end
                mon_req_q = host_bootdata_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_ready", byte_ready, 1'b1);
        chk("start_count", word_count, 0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall, input int ack_delay,
                             input int ack_hold, input int exp_count, input bit last);
        int  t0, t1, n;
        bit  got_low;
        exp_q.push_back(w);
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("collect_entry", byte_ready, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            if (stall) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
            byte_data  = w[i*8 +: 8];
            byte_valid = 1'b1;
            @(negedge clk);
        end
        // keep offering a junk byte while the word is out; it must not be taken
        byte_data = 8'hEE;
        chk("req_after_4th", host_bootdata_req, 1'b1);
        t1 = cyc;
        chk(stall ? "stall_collect_cycles" : "collect_cycles", 32'(t1 - t0), stall ? 32'd8 : 32'd4);
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            chk("ready_low_in_req", byte_ready, 1'b0);
        end
        host_bootdata_ack = 1'b1;
        got_low = 1'b0;
        for (int k = 0; k < ack_hold; k++) begin
            @(negedge clk);
            if (!host_bootdata_req && !got_low) begin
                got_low = 1'b1;
                chk("req_high_cycles", 32'(cyc - t1), 32'(ack_delay + 1));
                chk("word_count", word_count, 32'(exp_count));
            end
            chk("ready_low_ack_high", byte_ready, 1'b0);
        end
        if (!got_low) chk("req_drop", host_bootdata_req, 1'b0);
        host_bootdata_ack = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        if (last) chk("busy_after_last", busy, 1'b1);
        else      chk("ready_after_ack_fall", byte_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        byte_data = 8'h00;
        byte_valid = 1'b0;
        host_bootdata_ack = 1'b0;
        host_rom_initialised = 1'b0;
`ifdef BOOTDATA_CHECKSUM_EN
        expected_sum = 32'h0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_bootdata", host_bootdata, 32'h0);
        chk("rst_req", host_bootdata_req, 1'b0);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", word_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Upload 1: back-to-back, stalled source, slow ack, final word with ROM already loaded
        host_rom_initialised = 1'b1;
        do_start();
        send_word(32'h44332211, 1'b0, 1, 1, 1, 1'b0);
        send_word(32'h88776655, 1'b1, 1, 1, 2, 1'b0);
        send_word(32'hDDCCBBAA, 1'b0, 20, 5, 3, 1'b0);
        send_word(32'h0D0C0B0A, 1'b0, 1, 1, 4, 1'b1);
        chk("done_one_after_fall", done, 1'b0);
        @(negedge clk);
        chk("done_two_after_fall", done, 1'b1);
        chk("done_not_busy", busy, 1'b0);
        chk("done_count", word_count, 4);

        // Upload 2: restart from DONE, incrementing pattern, done held off by ROM init
        host_rom_initialised = 1'b0;
        do_start();
        send_word(32'hF3F2F1F0, 1'b0, 1, 1, 1, 1'b0);
        send_word(32'hF7F6F5F4, 1'b0, 1, 1, 2, 1'b0);
        send_word(32'hFBFAF9F8, 1'b0, 1, 1, 3, 1'b0);
        send_word(32'hFFFEFDFC, 1'b0, 1, 1, 4, 1'b1);
        repeat (10) @(negedge clk);
        chk("done_held_off", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", busy, 1'b1);
        chk("start_ignored_count", word_count, 4);
        host_rom_initialised = 1'b1;
        @(negedge clk);
        chk("done_after_rom_init", done, 1'b1);

`ifdef BOOTDATA_CHECKSUM_EN
        // Upload 3: checksum wraps to zero
        expected_sum = 32'h0;
        do_start();
        chk("sum_ok_low_busy", sum_ok, 1'b0);
        send_word(32'h00000001, 1'b0, 1, 1, 1, 1'b0);
        send_word(32'hFFFFFFFF, 1'b0, 1, 1, 2, 1'b0);
        send_word(32'h00000000, 1'b0, 1, 1, 3, 1'b0);
        send_word(32'h00000000, 1'b0, 1, 1, 4, 1'b1);
        @(negedge clk);
        chk("cs_done", done, 1'b1);
        chk("cs_sum", sum, 32'h0);
        chk("cs_sum_ok_match", sum_ok, 1'b1);
        expected_sum = 32'h1;
        #1;
        chk("cs_sum_ok_miss", sum_ok, 1'b0);
        @(negedge clk);
`endif

        // Reset in the middle of a word after one word has been acknowledged
        do_start();
        send_word(32'h0F1E2D3C, 1'b0, 1, 1, 1, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        @(negedge clk);
        byte_data  = 8'h98;
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bootdata", host_bootdata, 32'h0);
        chk("mid_rst_req", host_bootdata_req, 1'b0);
        chk("mid_rst_ready", byte_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_count", word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        send_word(32'h5A6B7C8D, 1'b0, 1, 1, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
